// File: rtl/in_data_unpackage_pkg.sv
// in_data_unpackage_pkg
//   Shared constants for the input-bit unpacker: stream word width and the
//   FSM state encodings (also used by the matching result packer).
package in_data_unpackage_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/in_data_unpackage_fifo.sv
// axis_word_fifo2
//   Two-entry word FIFO between the AXI-Stream slave and the bit serialiser.
//   The second entry lets the next word land while the current one is still
//   being shifted out, so word boundaries cost no idle cycle.
// Ports
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push/wdata : write a word (caller guarantees !full)
//   pop        : drop the head word (caller guarantees !empty)
//   head       : oldest word
//   full/empty : occupancy flags
module axis_word_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_idx;
  logic         rd_idx;
  logic [1:0]   cnt;

  assign head  = mem[rd_idx];
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_idx] <= wdata;
        wr_idx      <= ~wr_idx;
      end
      if (pop) begin
        rd_idx <= ~rd_idx;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/in_data_unpackage.sv
// in_data_unpackage
//   Takes AXI-Stream words from the DMA and serialises them LSB-first into a
//   1-bit stream for the compute array. Exactly cfg_bit_count bits are emitted
//   per layer; bits of a partial final word are dropped. layer_finish pulses
//   for one cycle (state DONE) after the final bit is taken.
// Ports
//   clk, rst_n       : clock, async active-low reset
//   start            : begin a layer (only looked at in IDLE)
//   cfg_bit_count    : bits for this layer, latched on start
//   s_axis_*         : word input (tdata, tvalid, tready, tlast)
//   out_valid/ready  : serial bit handshake; out_data is the bit
//   out_last         : qualifies the final bit of the layer
//   busy             : high outside IDLE
//   layer_finish     : one-cycle end-of-layer pulse
//   err_tlast        : sticky, tlast did not match the expected final word
//   dbg_state        : current FSM state
// Handshake: a transfer happens on a rising edge where valid && ready; valid
// never depends on ready, and data/last hold steady while valid is high and
// ready is low.
module in_data_unpackage
  import in_data_unpackage_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = WORD_W,
  parameter int CNT_WIDTH            = 24
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [CNT_WIDTH-1:0]            cfg_bit_count,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_data,
  output logic                            out_last,
  output logic                            busy,
  output logic                            layer_finish,
  output logic                            err_tlast,
  output logic [1:0]                      dbg_state
);

  localparam int PTR_W = $clog2(C_S_AXIS_TDATA_WIDTH);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(C_S_AXIS_TDATA_WIDTH - 1);

  logic [1:0]                      state;
  logic [CNT_WIDTH-1:0]            bits_left;
  logic [CNT_WIDTH-1:0]            words_left;
  logic [PTR_W-1:0]                rd_ptr;
  logic                            err_q;

  logic [C_S_AXIS_TDATA_WIDTH-1:0] fifo_head;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic                            push;
  logic                            pop;
  logic                            fire;
  logic                            last_bit;
  logic [CNT_WIDTH:0]              words_ceil;

  // ceil(cfg_bit_count / word width); one extra bit so the rounding add
  // cannot overflow.
  assign words_ceil = ({1'b0, cfg_bit_count}
                       + (CNT_WIDTH+1)'(C_S_AXIS_TDATA_WIDTH - 1)) >> PTR_W;

  // tready depends only on registered state, never on tvalid.
  assign s_axis_tready = (state == ST_RUN) && !fifo_full && (words_left != '0);
  assign push          = s_axis_tvalid && s_axis_tready;

  assign out_valid = (state == ST_RUN) && !fifo_empty;
  assign fire      = out_valid && out_ready;
  assign last_bit  = (bits_left == CNT_WIDTH'(1));
  // Head is released after its top bit, or early on the layer's final bit
  // (dropping the unused tail of a partial word).
  assign pop       = fire && ((rd_ptr == PTR_MAX) || last_bit);

  assign out_data     = out_valid && fifo_head[rd_ptr];
  assign out_last     = out_valid && last_bit;
  assign busy         = (state != ST_IDLE);
  assign layer_finish = (state == ST_DONE);
  assign err_tlast    = err_q;
  assign dbg_state    = state;

  axis_word_fifo2 #(
    .W (C_S_AXIS_TDATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (s_axis_tdata),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bits_left  <= '0;
      words_left <= '0;
      rd_ptr     <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_q  <= 1'b0;
            rd_ptr <= '0;
            if (cfg_bit_count != '0) begin
              state      <= ST_RUN;
              bits_left  <= cfg_bit_count;
              words_left <= words_ceil[CNT_WIDTH-1:0];
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (push) begin
            words_left <= words_left - CNT_WIDTH'(1);
            if (s_axis_tlast != (words_left == CNT_WIDTH'(1))) begin
              err_q <= 1'b1;
            end
          end
          if (fire) begin
            bits_left <= bits_left - CNT_WIDTH'(1);
            // Natural wrap covers the 31->0 step; the final bit forces 0.
            rd_ptr    <= last_bit ? '0 : rd_ptr + PTR_W'(1);
            if (last_bit) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_in_data_unpackage.sv
module tb_in_data_unpackage;

  localparam int W  = 32;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] cfg_bit_count = '0;
  logic [W-1:0]  s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          out_ready = 1'b0;
  logic          s_axis_tready;
  logic          out_valid;
  logic          out_data;
  logic          out_last;
  logic          busy;
  logic          layer_finish;
  logic          err_tlast;
  logic [1:0]    dbg_state;

  in_data_unpackage #(
    .C_S_AXIS_TDATA_WIDTH (W),
    .CNT_WIDTH            (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_bit_count (cfg_bit_count),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy),
    .layer_finish  (layer_finish),
    .err_tlast     (err_tlast),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass = 0;
  logic [1:0]  exp_q[$];          // {last, data}
  logic [31:0] layer_words [0:63];
  int          fires = 0;
  int          first_fire = 0;
  int          last_fire = 0;
  bit          ready_rand = 1'b0;
  bit          prev_stall = 1'b0;
  logic        prev_data = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e[0]);
          check("out_last", out_last, e[1]);
        end
        if (fires == 0) first_fire = cyc;
        last_fire = cyc;
        fires++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // ---------------- out_ready driver ----------------
  always @(posedge clk) begin
    #1;
    out_ready = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // ---------------- driver tasks ----------------
  // Reference model: bit i of the layer is bit (i%32) of word (i/32).
  task automatic push_expected(input int count);
    logic [31:0] w;
    for (int i = 0; i < count; i++) begin
      w = layer_words[i / 32];
      exp_q.push_back({(i == count - 1), w[i % 32]});
    end
  endtask

  task automatic do_start(input int count);
    cfg_bit_count = CW'(count);
    start = 1'b1;
    fires = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input int gap);
    bit ok;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (s_axis_tready) ok = 1'b1;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!ok) check("tready_timeout", 0, 1);
  endtask

  task automatic wait_finish(input int count);
    bit found;
    int fin;
    found = 1'b0;
    fin = 0;
    for (int t = 0; t < 5000 && !found; t++) begin
      @(negedge clk);
      if (layer_finish) begin
        found = 1'b1;
        fin = cyc;
      end
    end
    check("layer_finish_seen", found, 1);
    if (found && count > 0) check("finish_after_last", fin - last_fire, 1);
    check("bit_count", fires, count);
    check("queue_drained", exp_q.size(), 0);
    @(negedge clk);
    check("finish_one_cycle", layer_finish, 0);
    check("idle_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_tready", s_axis_tready, 0);
    check("rst_finish", layer_finish, 0);
    check("rst_err", err_tlast, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: two full words, back to back
    layer_words[0] = 32'hA5A5_A5A5;
    layer_words[1] = 32'h0000_FFFF;
    push_expected(64);
    do_start(64);
    check("t1_busy", busy, 1);
    send_word(layer_words[0], 1'b0, 0);
    send_word(layer_words[1], 1'b1, 0);
    wait_finish(64);
    check("t1_no_bubble", last_fire - first_fire, 63);
    check("t1_err", err_tlast, 0);

    // 2: partial final word, extra word refused
    begin
      bit seen_ready;
      layer_words[0] = 32'hFFFF_FFFF;
      layer_words[1] = 32'h0000_00AA;
      push_expected(40);
      do_start(40);
      send_word(layer_words[0], 1'b0, 0);
      send_word(layer_words[1], 1'b1, 0);
      s_axis_tdata  = 32'hDEAD_BEEF;
      s_axis_tvalid = 1'b1;
      seen_ready = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if (s_axis_tready) seen_ready = 1'b1;
      end
      check("t2_extra_tready", seen_ready, 0);
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
      wait_finish(40);
      check("t2_no_bubble", last_fire - first_fire, 39);
      check("t2_err", err_tlast, 0);
    end

    // 3: zero-length layer
    do_start(0);
    @(negedge clk);
    check("t3_finish", layer_finish, 1);
    check("t3_busy", busy, 1);
    check("t3_tready", s_axis_tready, 0);
    check("t3_state", dbg_state, 2);
    @(negedge clk);
    check("t3_finish_off", layer_finish, 0);
    check("t3_busy_off", busy, 0);
    check("t3_bits", fires, 0);
    @(posedge clk); #1;

    // 4: 1000 bits, random back-pressure and input gaps
    for (int i = 0; i < 32; i++) layer_words[i] = $urandom;
    push_expected(1000);
    ready_rand = 1'b1;
    do_start(1000);
    for (int i = 0; i < 32; i++) send_word(layer_words[i], (i == 31), $urandom_range(0, 3));
    wait_finish(1000);
    ready_rand = 1'b0;
    check("t4_err", err_tlast, 0);

    // 5: tlast on the first of three words
    layer_words[0] = 32'h1111_1111;
    layer_words[1] = 32'h2222_2222;
    layer_words[2] = 32'h3333_3333;
    push_expected(96);
    do_start(96);
    send_word(layer_words[0], 1'b1, 0);
    send_word(layer_words[1], 1'b0, 0);
    send_word(layer_words[2], 1'b1, 0);
    wait_finish(96);
    check("t5_err_set", err_tlast, 1);
    repeat (5) @(posedge clk);
    #1;
    check("t5_err_sticky", err_tlast, 1);
    do_start(0);
    @(negedge clk);
    check("t5_err_cleared", err_tlast, 0);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;

    // 6: reset in the middle of a word
    layer_words[0] = 32'hCAFE_F00D;
    layer_words[1] = 32'h0BAD_0BAD;
    push_expected(64);
    do_start(64);
    send_word(layer_words[0], 1'b0, 0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_valid", out_valid, 0);
    check("t6_data", out_data, 0);
    check("t6_last", out_last, 0);
    check("t6_busy", busy, 0);
    check("t6_tready", s_axis_tready, 0);
    check("t6_finish", layer_finish, 0);
    exp_q.delete();
    fires = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_idle_valid", out_valid, 0);
    layer_words[0] = 32'h1234_5678;
    push_expected(32);
    do_start(32);
    send_word(layer_words[0], 1'b1, 0);
    wait_finish(32);
    check("t6_err", err_tlast, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
